// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bundle for the bit-serial adder controller.
// The requester drives through master; the adder controller connects through slave.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over WIDTH cycles,
// with operand/sum shift registers, carry flop, bit counter and start/done handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             s_bit_c;
    logic             co_c;
    logic [WIDTH-1:0] s_next_c;

    // Full-adder cell on the current LSBs and the carry flop.
    assign s_bit_c = a_sr[0] ^ b_sr[0] ^ carry;
    assign co_c    = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (a_sr[0] & carry);

    // New sum bit enters at the MSB so the word is LSB-aligned after WIDTH shifts;
    // the widened shift keeps WIDTH=1 legal without a zero-width slice.
    assign s_next_c = WIDTH'({s_bit_c, s_sr} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin : p_fsm
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        s_sr   <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    s_sr  <= s_next_c;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= co_c;
                    cnt   <= cnt + CNT_W'(1);
                    // Result registers are only written on the last bit.
                    if (cnt == LAST_BIT) begin
                        sum_q  <= s_next_c;
                        cout_q <= co_c;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=4 main instance plus WIDTH=1 and WIDTH=8 builds.
// Drivers push expected {cout,sum} and accept edge; a negedge monitor pops on done.
module tb_serial_adder_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(4)) if4 ();
    serial_adder_ctrl_if #(.WIDTH(1)) if1 ();
    serial_adder_ctrl_if #(.WIDTH(8)) if8 ();

    serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    typedef struct {
        logic [8:0] res;
        int         e_idx;
    } exp_t;

    exp_t       q4[$];
    exp_t       q1[$];
    exp_t       q8[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         next_free[3];
    logic [8:0] last_res[3];

    // Edge counter: after edge k, cyc == k until the next edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wof(input int inst);
        case (inst)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [8:0] model(input int inst, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
        logic [7:0] m;
        m = 8'((9'd1 << wof(inst)) - 9'd1);
        return 9'(a & m) + 9'(b & m) + 9'(ci);
    endfunction

    function automatic int q_size(input int inst);
        case (inst)
            0:       return q4.size();
            1:       return q1.size();
            default: return q8.size();
        endcase
    endfunction

    function automatic exp_t q_front(input int inst);
        case (inst)
            0:       return q4[0];
            1:       return q1[0];
            default: return q8[0];
        endcase
    endfunction

    task automatic q_pop(input int inst);
        exp_t d;
        case (inst)
            0:       d = q4.pop_front();
            1:       d = q1.pop_front();
            default: d = q8.pop_front();
        endcase
    endtask

    task automatic q_push(input int inst, input exp_t e);
        case (inst)
            0:       q4.push_back(e);
            1:       q1.push_back(e);
            default: q8.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic set_in(input int inst, input logic st, input logic [7:0] a,
                          input logic [7:0] b, input logic ci);
        case (inst)
            0: begin if4.start = st; if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = ci; end
            1: begin if1.start = st; if1.a = a[0:0]; if1.b = b[0:0]; if1.cin = ci; end
            default: begin if8.start = st; if8.a = a; if8.b = b; if8.cin = ci; end
        endcase
    endtask

    // Record an accept at the coming edge; the model is IDLE again WIDTH+2 edges later.
    task automatic accept(input int inst, input logic [7:0] a, input logic [7:0] b, input logic ci);
        exp_t e;
        e.res   = model(inst, a, b, ci);
        e.e_idx = cyc + 1;
        q_push(inst, e);
        next_free[inst] = cyc + 1 + wof(inst) + 2;
    endtask

    // One-cycle start pulse; operands are scrambled afterwards to prove they were captured.
    task automatic issue(input int inst, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        while (cyc + 1 < next_free[inst]) @(negedge clk);
        set_in(inst, 1'b1, a, b, ci);
        accept(inst, a, b, ci);
        @(negedge clk);
        set_in(inst, 1'b0, ~a, ~b, ~ci);
    endtask

    task automatic mon(input int inst, input logic busy, input logic done, input logic [8:0] res);
        exp_t h;
        int   sz;
        logic exp_busy;
        sz = q_size(inst);
        if (sz > 0) h = q_front(inst);
        exp_busy = (sz > 0) && (cyc >= h.e_idx) && (cyc < h.e_idx + wof(inst));
        chk($sformatf("busy_w%0d", wof(inst)), 9'(busy), 9'(exp_busy));
        if (done) begin
            if (sz == 0) begin
                chk($sformatf("done_without_op_w%0d", wof(inst)), 9'(done), 9'd0);
            end else begin
                q_pop(inst);
                chk($sformatf("sum_w%0d", wof(inst)), res, h.res);
                chk($sformatf("latency_w%0d", wof(inst)), 9'(cyc - h.e_idx), 9'(wof(inst)));
                last_res[inst] = h.res;
            end
        end else begin
            chk($sformatf("hold_w%0d", wof(inst)), res, last_res[inst]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if4.busy, if4.done, 9'({if4.cout, if4.sum}));
            mon(1, if1.busy, if1.done, 9'({if1.cout, if1.sum}));
            mon(2, if8.busy, if8.done, 9'({if8.cout, if8.sum}));
        end
    end

    task automatic clear_model();
        q4.delete();
        q1.delete();
        q8.delete();
        for (int i = 0; i < 3; i++) begin
            next_free[i] = 0;
            last_res[i]  = 9'd0;
        end
    endtask

    // Asynchronous reset landing mid-cycle, one edge after the caller's accept.
    task automatic reset_mid(input logic check_now);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        if (check_now) begin
            chk("rst_busy", 9'(if4.busy), 9'd0);
            chk("rst_done", 9'(if4.done), 9'd0);
            chk("rst_sum",  9'(if4.sum),  9'd0);
            chk("rst_cout", 9'(if4.cout), 9'd0);
        end
        clear_model();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() + q1.size() + q8.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 9'(q4.size() + q1.size() + q8.size()), 9'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'h00, 8'h00, 1'b0);
        clear_model();
        #1 rst_n = 1'b0;
        #1;
        chk("por_busy", 9'(if4.busy), 9'd0);
        chk("por_done", 9'(if4.done), 9'd0);
        chk("por_sum",  9'({if4.cout, if4.sum}), 9'd0);
        chk("por_sum8", 9'({if8.cout, if8.sum}), 9'd0);
        #20 rst_n = 1'b1;

        // Directed single operations.
        issue(0, 8'h05, 8'h03, 1'b0);   // 0x08
        issue(0, 8'h0F, 8'h01, 1'b0);   // 0x10
        issue(0, 8'h0F, 8'h0F, 1'b1);   // 0x1F
        drain();

        // Reset during ADD: outputs clear immediately, aborted op never completes.
        issue(0, 8'h07, 8'h01, 1'b0);
        reset_mid(1'b1);
        repeat (8) @(negedge clk);
        issue(0, 8'h09, 8'h06, 1'b0);
        reset_mid(1'b0);
        repeat (8) @(negedge clk);
        issue(0, 8'h02, 8'h02, 1'b0);   // 0x04
        drain();

        // Start held high with operands changing every cycle.
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            set_in(0, 1'b1, 8'(k * 3 + 1), 8'(k * 5 + 2), k[0]);
            if (cyc + 1 >= next_free[0]) accept(0, 8'(k * 3 + 1), 8'(k * 5 + 2), k[0]);
            @(negedge clk);
        end
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drain();

        // Exhaustive WIDTH=4 and WIDTH=1, directed WIDTH=8, in parallel.
        fork
            begin
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        for (int c = 0; c < 2; c++)
                            issue(0, 8'(a), 8'(b), c[0]);
            end
            begin
                for (int v = 0; v < 8; v++) issue(1, 8'(v >> 2), 8'(v >> 1), v[0]);
            end
            begin
                issue(2, 8'hFF, 8'h01, 1'b0);   // 0x100
                issue(2, 8'hFF, 8'hFF, 1'b1);   // 0x1FF
                issue(2, 8'h80, 8'h80, 1'b0);   // 0x100
                issue(2, 8'h12, 8'h34, 1'b1);   // 0x047
                issue(2, 8'hAA, 8'h55, 1'b1);   // 0x100
                issue(2, 8'h00, 8'h00, 1'b0);   // 0x000
                issue(2, 8'h7F, 8'h01, 1'b0);   // 0x080
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
